// File: rtl/ahfp_norm.sv
// ahfp_norm: multicycle normaliser for single-precision adder/subtractor results.
// Takes the sign, the exponent and a raw 25-bit magnitude. It shifts the magnitude
// until bit 23 holds the leading one, adjusts the exponent, and packs an IEEE-754 single.
// The block uses a start/done multicycle custom-instruction handshake.
//
// Parameters:
//   LZ_STEP  left-shift stride per cycle while the top LZ_STEP bits of m[23:0] are zero (1,2,4,8)
// Configuration macro:
//   AHFP_NORM_ROUND_EN  keep the right-shifted guard bit and round ties-to-even;
//                       undefined -> truncate, no rounding logic
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   clk_en  in   clock enable; low freezes all registers
//   start   in   request, sampled in IDLE when clk_en=1
//   dataa   in   [31]=sign, [30:23]=exponent
//   datab   in   [24:0]=raw magnitude (bit24 carry, bit23 hidden one)
//   done    out  one-cycle completion pulse
//   result  out  packed IEEE single, held until the next completion
module ahfp_norm #(
  parameter int unsigned LZ_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned MW = 25;
  localparam int unsigned EW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   m_q, m_d;
  logic [EW-1:0]   e_q, e_d;
  logic            s_q, s_d;
  logic            done_q, done_d;
  logic [31:0]     result_q, result_d;
`ifdef AHFP_NORM_ROUND_EN
  logic            g_q, g_d;
`endif

  logic            lz_zero;
  logic            big_step;
  logic            unused_inputs;

  // Only sign/exponent of dataa and the 25-bit magnitude of datab are meaningful
  assign unused_inputs = ^{dataa[22:0], datab[31:25]};

  // A wide left step is taken only when it cannot push the exponent to zero or below
  assign lz_zero  = (m_q[23 -: LZ_STEP] == '0);
  assign big_step = lz_zero && (e_q > EW'(LZ_STEP));

  // Next-state and datapath: one normalisation action per NORM cycle
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    s_d      = s_q;
    done_d   = 1'b0;
    result_d = result_q;
`ifdef AHFP_NORM_ROUND_EN
    g_d      = g_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = dataa[31];
          e_d     = dataa[30:23];
          m_d     = datab[MW-1:0];
`ifdef AHFP_NORM_ROUND_EN
          g_d     = 1'b0;
`endif
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (e_q == 8'hFF) begin
          result_d = {s_q, 8'hFF, m_q[22:0]};
          state_d  = ST_DONE;
        end else if ((m_q == '0) || (e_q == '0)) begin
          result_d = {s_q, 31'b0};
          state_d  = ST_DONE;
        end else if (m_q[24]) begin
          if (e_q == 8'hFE) begin
            result_d = {s_q, 8'hFF, 23'b0};
            state_d  = ST_DONE;
          end else begin
            m_d = m_q >> 1;
            e_d = e_q + EW'(1);
`ifdef AHFP_NORM_ROUND_EN
            g_d = m_q[0];
`endif
          end
        end else if (m_q[23]) begin
`ifdef AHFP_NORM_ROUND_EN
          // Guard set and odd lsb rounds up; a carry into bit24 is handled next cycle
          if (g_q && m_q[0]) begin
            m_d = m_q + MW'(1);
            g_d = 1'b0;
          end else begin
            result_d = {s_q, e_q, m_q[22:0]};
            state_d  = ST_DONE;
          end
`else
          result_d = {s_q, e_q, m_q[22:0]};
          state_d  = ST_DONE;
`endif
        end else begin
          if (e_q == EW'(1)) begin
            result_d = {s_q, 31'b0};
            state_d  = ST_DONE;
          end else if (big_step) begin
            m_d = m_q << LZ_STEP;
            e_d = e_q - EW'(LZ_STEP);
          end else begin
            m_d = m_q << 1;
            e_d = e_q - EW'(1);
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, frozen while clk_en is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      e_q      <= '0;
      s_q      <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef AHFP_NORM_ROUND_EN
      g_q      <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      s_q      <= s_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef AHFP_NORM_ROUND_EN
      g_q      <= g_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_ahfp_norm.sv
// tb_ahfp_norm: directed vectors for ahfp_norm with LZ_STEP=1 and LZ_STEP=8
// instances sharing the same stimulus; latency is counted in clock edges after
// the start edge.
module tb_ahfp_norm;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done,   done8;
  logic [31:0] result, result8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ahfp_norm #(.LZ_STEP(1)) u_dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .done(done), .result(result)
  );

  ahfp_norm #(.LZ_STEP(8)) u_dut8 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .done(done8), .result(result8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op; optional clk_en stall and stray start pulse at given cycle counts
  task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input int stall_at, input int inject_at,
                        output int lat, output int lat8,
                        output logic [31:0] res, output logic [31:0] res8);
    int cyc;
    lat  = -1;
    lat8 = -1;
    res  = '0;
    res8 = '0;
    @(negedge clk);
    dataa = {s, e, 23'h5A5A5};
    datab = {7'h7F, m};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dataa = 32'hFFFF_FFFF;
    datab = 32'hFFFF_FFFF;
    cyc = 0;
    while ((lat < 0 || lat8 < 0) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done  && lat  < 0) begin lat  = cyc; res  = result;  end
      if (done8 && lat8 < 0) begin lat8 = cyc; res8 = result8; end
      if (cyc == stall_at)     clk_en = 1'b0;
      if (cyc == stall_at + 5) clk_en = 1'b1;
      if (cyc == inject_at)     start = 1'b1;
      if (cyc == inject_at + 1) start = 1'b0;
    end
    clk_en = 1'b1;
    start  = 1'b0;
  endtask

  // Directed case: both instances must produce res with their respective latencies
  task automatic vec(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m,
                     input logic [31:0] exp_res, input int exp_lat, input int exp_lat8,
                     input int stall_at, input int inject_at);
    int lat, lat8;
    logic [31:0] res, res8;
    run_op(s, e, m, stall_at, inject_at, lat, lat8, res, res8);
    check({tag, "_res"},   res,  exp_res);
    check({tag, "_lat"},   32'(lat),  32'(exp_lat));
    check({tag, "_res8"},  res8, exp_res);
    check({tag, "_lat8"},  32'(lat8), 32'(exp_lat8));
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, {30'b0, done, done8}, 32'h0);
  endtask

  initial begin
    int extra;
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = '0;
    datab  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",   {30'b0, done, done8}, 32'h0);
    check("rst_result", result,  32'h0);
    check("rst_result8", result8, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    vec("norm",     1'b0, 8'h80, 25'h0800000, 32'h4000_0000, 2, 2, -10, -10);
    vec("carry",    1'b0, 8'h80, 25'h1000000, 32'h4080_0000, 3, 3, -10, -10);
    vec("ovf_inf",  1'b0, 8'hFE, 25'h1000000, 32'h7F80_0000, 2, 2, -10, -10);
    vec("lz_small", 1'b1, 8'h80, 25'h0000001, 32'hB480_0000, 25, 11, -10, -10);
    vec("zero",     1'b1, 8'h80, 25'h0000000, 32'h8000_0000, 2, 2, -10, -10);
    vec("flush",    1'b0, 8'h03, 25'h0000001, 32'h0000_0000, 4, 4, -10, -10);
    vec("nan",      1'b0, 8'hFF, 25'h0400001, 32'h7FC0_0001, 2, 2, -10, -10);
    vec("denorm",   1'b1, 8'h00, 25'h0800000, 32'h8000_0000, 2, 2, -10, -10);
`ifdef AHFP_NORM_ROUND_EN
    vec("round",    1'b0, 8'h80, 25'h1000003, 32'h4080_0002, 4, 4, -10, -10);
`else
    vec("round",    1'b0, 8'h80, 25'h1000003, 32'h4080_0001, 3, 3, -10, -10);
`endif
    vec("stall",    1'b1, 8'h80, 25'h0000001, 32'hB480_0000, 30, 16, 5, -10);
    vec("inject",   1'b1, 8'h80, 25'h0000001, 32'hB480_0000, 25, 11, -10, 3);

    // No further done may appear after the stray start pulse
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || done8) extra++;
    end
    check("inject_no_extra", 32'(extra), 32'h0);

    // Reset in the middle of a long normalisation aborts with no done
    @(negedge clk);
    dataa = {1'b1, 8'h80, 23'h0};
    datab = {7'h0, 25'h0000001};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || done8) extra++;
    end
    check("abort_no_done", 32'(extra), 32'h0);
    check("abort_result",  result,  32'h0);
    check("abort_result8", result8, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
